hazard_control_unit: RTL and testbench

//  Pipeline sequencer that works alongside the operand forwarding mux in EX.

---
 rtl/hazard_control_unit_if.sv | 47 ++++
 rtl/hazard_control_unit.sv | 110 +++++++++++
 tb/tb_hazard_control_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-side signal bundle of the hazard control unit
interface hazard_control_unit_if #(
   parameter int REG_W = 5
);
   logic [REG_W-1:0] rs1_OF;
   logic [REG_W-1:0] rs2_OF;
   logic             use_rs1_OF;
   logic             use_rs2_OF;
   logic [REG_W-1:0] rd_EX;
   logic             is_load_EX;
   logic             ext_start_EX;
   logic             branch_taken_EX;
   logic             stall_PC;
   logic             stall_IF_OF;
   logic             stall_OF_EX;
   logic             bubble_EX;
   logic             bubble_DM;
   logic             flush_IF_OF;
   logic             flush_OF_EX;
   logic             ext_busy;
   logic             ext_done;
   logic [REG_W-1:0] rd_EXT_fwd;
`ifdef HAZARD_STATS_EN
   logic [15:0]      stall_cycles;
   logic [15:0]      flush_count;
`endif

   modport master (
      output rs1_OF, rs2_OF, use_rs1_OF, use_rs2_OF, rd_EX,
      output is_load_EX, ext_start_EX, branch_taken_EX,
      input  stall_PC, stall_IF_OF, stall_OF_EX, bubble_EX, bubble_DM,
      input  flush_IF_OF, flush_OF_EX, ext_busy, ext_done, rd_EXT_fwd
`ifdef HAZARD_STATS_EN
      , input stall_cycles, flush_count
`endif
   );

   modport slave (
      input  rs1_OF, rs2_OF, use_rs1_OF, use_rs2_OF, rd_EX,
      input  is_load_EX, ext_start_EX, branch_taken_EX,
      output stall_PC, stall_IF_OF, stall_OF_EX, bubble_EX, bubble_DM,
      output flush_IF_OF, flush_OF_EX, ext_busy, ext_done, rd_EXT_fwd
`ifdef HAZARD_STATS_EN
      , output stall_cycles, flush_count
`endif
   );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use/EXT/branch hazard sequencer; HAZARD_STATS_EN adds stall/flush counters
module hazard_control_unit #(
   parameter int REG_W       = 5,
   parameter int EXT_LATENCY = 4,
   parameter int CNT_W       = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   hazard_control_unit_if.slave  hz
);
   typedef enum logic {RUN, EXTWAIT} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXT_LATENCY - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [REG_W-1:0] rd_hold;
   logic             load_use;

   assign load_use = hz.is_load_EX && (hz.rd_EX != '0) &&
                     ((hz.use_rs1_OF && (hz.rs1_OF == hz.rd_EX)) ||
                      (hz.use_rs2_OF && (hz.rs2_OF == hz.rd_EX)));

   always_comb begin
      hz.stall_PC    = 1'b0;
      hz.stall_IF_OF = 1'b0;
      hz.stall_OF_EX = 1'b0;
      hz.bubble_EX   = 1'b0;
      hz.bubble_DM   = 1'b0;
      hz.flush_IF_OF = 1'b0;
      hz.flush_OF_EX = 1'b0;
      hz.ext_busy    = 1'b0;
      hz.ext_done    = 1'b0;
      hz.rd_EXT_fwd  = '0;
      if (!rst) begin
         if (state == RUN) begin
            if (hz.branch_taken_EX) begin
               hz.flush_IF_OF = 1'b1;
               hz.flush_OF_EX = 1'b1;
            end else if (hz.ext_start_EX) begin
               if (EXT_LATENCY == 1) begin
                  hz.ext_done   = 1'b1;
                  hz.rd_EXT_fwd = hz.rd_EX;
               end else begin
                  hz.stall_PC    = 1'b1;
                  hz.stall_IF_OF = 1'b1;
                  hz.stall_OF_EX = 1'b1;
                  hz.bubble_DM   = 1'b1;
                  hz.ext_busy    = 1'b1;
               end
            end else if (load_use) begin
               // The bubble removes the load from EX, so this releases itself next cycle.
               hz.stall_PC    = 1'b1;
               hz.stall_IF_OF = 1'b1;
               hz.bubble_EX   = 1'b1;
            end
         end else if (cnt > CNT_ONE) begin
            hz.stall_PC    = 1'b1;
            hz.stall_IF_OF = 1'b1;
            hz.stall_OF_EX = 1'b1;
            hz.bubble_DM   = 1'b1;
            hz.ext_busy    = 1'b1;
         end else begin
            hz.ext_done   = 1'b1;
            hz.rd_EXT_fwd = rd_hold;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         cnt     <= '0;
         rd_hold <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!hz.branch_taken_EX && hz.ext_start_EX && (EXT_LATENCY > 1)) begin
                  state   <= EXTWAIT;
                  cnt     <= CNT_INIT;
                  rd_hold <= hz.rd_EX;
               end
            end
            default: begin
               if (cnt > CNT_ONE) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  state <= RUN;
                  cnt   <= '0;
               end
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hz.stall_cycles <= '0;
         hz.flush_count  <= '0;
      end else begin
         if (hz.stall_PC && (hz.stall_cycles != 16'hFFFF))
            hz.stall_cycles <= hz.stall_cycles + 16'd1;
         if (hz.flush_IF_OF && (hz.flush_count != 16'hFFFF))
            hz.flush_count <= hz.flush_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed table plus randomized model check of hazard_control_unit
module tb_hazard_control_unit;
   localparam int REG_W = 5;
   localparam int LAT   = 4;

   typedef struct {
      logic             rst;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic             u1;
      logic             u2;
      logic [REG_W-1:0] rd;
      logic             ld;
      logic             ext;
      logic             br;
      logic [13:0]      exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   vec_t vecs[$];

   bit               m_act  = 1'b0;
   int               m_start = 0;
   int               m_cyc  = 0;
   logic [REG_W-1:0] m_hold = '0;

   hazard_control_unit_if #(.REG_W(REG_W)) hz();
   hazard_control_unit #(.REG_W(REG_W), .EXT_LATENCY(LAT), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .hz(hz)
   );

   always #5 clk = ~clk;

   // Output order: stall_PC stall_IF_OF stall_OF_EX bubble_EX bubble_DM flush_IF_OF flush_OF_EX ext_busy ext_done rd
   function automatic logic [13:0] pack_out();
      return {hz.stall_PC, hz.stall_IF_OF, hz.stall_OF_EX, hz.bubble_EX, hz.bubble_DM,
              hz.flush_IF_OF, hz.flush_OF_EX, hz.ext_busy, hz.ext_done, hz.rd_EXT_fwd};
   endfunction

   task automatic add(input logic r, input int rs1, input int rs2, input logic u1, input logic u2,
                      input int rd, input logic ld, input logic ext, input logic br,
                      input logic [8:0] flags, input int erd);
      vec_t v;
      v.rst = r; v.rs1 = REG_W'(rs1); v.rs2 = REG_W'(rs2); v.u1 = u1; v.u2 = u2;
      v.rd = REG_W'(rd); v.ld = ld; v.ext = ext; v.br = br;
      v.exp = {flags, REG_W'(erd)};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst;
      hz.rs1_OF = v.rs1; hz.rs2_OF = v.rs2;
      hz.use_rs1_OF = v.u1; hz.use_rs2_OF = v.u2;
      hz.rd_EX = v.rd; hz.is_load_EX = v.ld;
      hz.ext_start_EX = v.ext; hz.branch_taken_EX = v.br;
   endtask

   // Reference: an EXT op started at cycle S stalls through S+LAT-2 and completes at S+LAT-1.
   function automatic logic [13:0] model(input vec_t v);
      logic [8:0] f;
      logic [REG_W-1:0] r;
      int k;
      bit hit;
      f = '0; r = '0;
      hit = v.ld && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      k = m_cyc - m_start;
      if (v.rst) begin
         f = '0;
      end else if (m_act) begin
         if (k < LAT - 1) f = 9'b111010010;
         else begin f = 9'b000000001; r = m_hold; end
      end else if (v.br) f = 9'b000001100;
      else if (v.ext) begin
         if (LAT == 1) begin f = 9'b000000001; r = v.rd; end
         else f = 9'b111010010;
      end else if (hit) f = 9'b110100000;
      return {f, r};
   endfunction

   task automatic model_step(input vec_t v);
      if (v.rst) m_act = 1'b0;
      else if (m_act) begin
         if (m_cyc - m_start >= LAT - 1) m_act = 1'b0;
      end else if (!v.br && v.ext && LAT > 1) begin
         m_act = 1'b1; m_start = m_cyc; m_hold = v.rd;
      end
      m_cyc++;
   endtask

   task automatic cycle(input vec_t v, output logic [13:0] got);
      drive(v);
      @(negedge clk);
      got = pack_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [13:0] got;
      logic [13:0] exp;
      vec_t v;
      rst = 1'b1;
      drive('{1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0});

      //   rst rs1 rs2 u1 u2 rd ld ext br  flags          rd
      add(1, 3, 0, 1, 0, 3, 1, 1, 1, 9'b000000000, 0);  // reset: all outputs 0
      add(0, 3, 0, 1, 0, 3, 1, 0, 0, 9'b110100000, 0);  // load-use rs1
      add(0, 3, 0, 1, 0, 3, 0, 0, 0, 9'b000000000, 0);  // bubble cleared the load
      add(0, 0, 0, 1, 0, 0, 1, 0, 0, 9'b000000000, 0);  // rd=0 never hazards
      add(0, 3, 0, 0, 0, 3, 1, 0, 0, 9'b000000000, 0);  // rs1 unused
      add(0, 1, 9, 0, 1, 9, 1, 0, 0, 9'b110100000, 0);  // load-use rs2
      add(0, 3, 0, 1, 0, 3, 1, 0, 1, 9'b000001100, 0);  // branch beats load-use
      add(0, 0, 0, 0, 0, 7, 0, 1, 0, 9'b111010010, 0);  // EXT start
      add(0, 3, 0, 1, 0, 3, 1, 0, 1, 9'b111010010, 0);  // EXTWAIT ignores branch/load
      add(0, 0, 0, 0, 0, 5, 0, 1, 0, 9'b111010010, 0);  // EXTWAIT ignores ext_start
      add(0, 0, 0, 0, 0, 2, 0, 0, 0, 9'b000000001, 7);  // done, forwards held tag
      add(0, 0, 0, 0, 0, 2, 0, 0, 0, 9'b000000000, 0);  // back in RUN
      add(0, 0, 0, 0, 0, 6, 0, 1, 1, 9'b000001100, 0);  // branch beats ext_start
      add(0, 0, 0, 0, 0, 6, 0, 0, 0, 9'b000000000, 0);  // stayed in RUN
      add(0, 0, 0, 0, 0, 7, 0, 1, 0, 9'b111010010, 0);  // EXT start
      add(1, 0, 0, 0, 0, 7, 0, 0, 0, 9'b000000000, 0);  // reset mid-op
      add(0, 0, 0, 0, 0, 7, 0, 0, 0, 9'b000000000, 0);  // RUN, no stall
      add(0, 0, 0, 0, 0, 7, 0, 0, 0, 9'b000000000, 0);  // abandoned op never completes
      add(0, 0, 0, 0, 0, 7, 0, 0, 0, 9'b000000000, 0);
      add(0, 4, 0, 1, 0, 4, 1, 0, 0, 9'b110100000, 0);  // load-use still works

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i], got);
         check($sformatf("vec%0d", i), got, vecs[i].exp);
      end

      // back-to-back EXT ops: second start accepted the cycle after done
      m_act = 1'b0; m_cyc = 0; m_start = 0;
      v = '{1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0};
      cycle(v, got); model_step(v);
      for (int n = 0; n < 2 * LAT; n++) begin
         v = '{1'b0, '0, '0, 1'b0, 1'b0, REG_W'(n + 10), 1'b0, 1'b1, 1'b0, '0};
         exp = model(v);
         cycle(v, got);
         check($sformatf("b2b%0d", n), got, exp);
         model_step(v);
      end

      for (int n = 0; n < 3000; n++) begin
         v.rst = ($urandom_range(0, 59) == 0);
         v.rs1 = REG_W'($urandom_range(0, 3));
         v.rs2 = REG_W'($urandom_range(0, 3));
         v.u1  = $urandom_range(0, 1) == 1;
         v.u2  = $urandom_range(0, 1) == 1;
         v.rd  = REG_W'($urandom_range(0, 3));
         v.ld  = $urandom_range(0, 1) == 1;
         v.ext = ($urandom_range(0, 5) == 0);
         v.br  = ($urandom_range(0, 7) == 0);
         exp = model(v);
         cycle(v, got);
         check($sformatf("rand%0d", n), got, exp);
         model_step(v);
      end

`ifdef HAZARD_STATS_EN
      v = '{1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0};
      cycle(v, got);
      v = '{1'b0, '0, '0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, '0};
      cycle(v, got);
      v.ext = 1'b0;
      for (int n = 0; n < LAT; n++) cycle(v, got);
      v = '{1'b0, 5'd3, '0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, '0};
      cycle(v, got);
      check("stall_cycles", {hz.stall_cycles[13:0]}, 14'd3);
      check("flush_count", {hz.flush_count[13:0]}, 14'd1);
      v.br = 1'b0;
      drive(v);
      repeat (70000) @(posedge clk);
      #1;
      check("stall_sat_lo", hz.stall_cycles[13:0], 14'h3FFF);
      check("stall_sat_hi", {12'd0, hz.stall_cycles[15:14]}, 14'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
